// File: rtl/rip_mmio_pkg.sv
// Shared definitions for the MMIO responder: register offsets, request size
// encoding, UART shifter states and UART_STATUS bit positions.
package rip_mmio_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned OFF_W  = 8;

    localparam logic [OFF_W-1:0] OFF_MTIME_LO    = 8'h00;
    localparam logic [OFF_W-1:0] OFF_MTIME_HI    = 8'h04;
    localparam logic [OFF_W-1:0] OFF_MTIMECMP_LO = 8'h08;
    localparam logic [OFF_W-1:0] OFF_MTIMECMP_HI = 8'h0C;
    localparam logic [OFF_W-1:0] OFF_UART_TXDATA = 8'h10;
    localparam logic [OFF_W-1:0] OFF_UART_STATUS = 8'h14;

    localparam int unsigned ST_BUSY    = 0;
    localparam int unsigned ST_FULL    = 1;
    localparam int unsigned ST_EMPTY   = 2;
    localparam int unsigned ST_OVF     = 3;
    localparam int unsigned ST_CNT_LSB = 4;
    localparam int unsigned ST_CNT_W   = 4;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10,
        SIZE_RSVD = 2'b11
    } req_size_e;

    typedef enum logic [1:0] {
        UART_IDLE  = 2'b00,
        UART_START = 2'b01,
        UART_DATA  = 2'b10,
        UART_STOP  = 2'b11
    } uart_state_e;

    // Offset is mapped for this direction; mtime halves are read-only.
    function automatic logic reg_mapped(input logic [OFF_W-1:0] off, input logic we);
        logic ok;
        case (off)
            OFF_MTIME_LO, OFF_MTIME_HI:           ok = !we;
            OFF_MTIMECMP_LO, OFF_MTIMECMP_HI,
            OFF_UART_TXDATA, OFF_UART_STATUS:     ok = 1'b1;
            default:                              ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/rip_mmio_responder_if.sv
// Request/response bus between the memory unit and the MMIO responder.
interface rip_mmio_responder_if;
    import rip_mmio_pkg::*;

    logic              REQ_VALID;
    logic              REQ_WE;
    logic [1:0]        REQ_SIZE;
    logic [ADDR_W-1:0] REQ_ADDR;
    logic [DATA_W-1:0] REQ_WDATA;
    logic              RSP_VALID;
    logic [DATA_W-1:0] RSP_RDATA;
    logic              RSP_ERR;

    modport master (
        output REQ_VALID, REQ_WE, REQ_SIZE, REQ_ADDR, REQ_WDATA,
        input  RSP_VALID, RSP_RDATA, RSP_ERR
    );

    modport slave (
        input  REQ_VALID, REQ_WE, REQ_SIZE, REQ_ADDR, REQ_WDATA,
        output RSP_VALID, RSP_RDATA, RSP_ERR
    );

endinterface

// File: rtl/rip_uart_tx.sv
// 8N1 UART transmitter: byte FIFO feeding a start/data/stop shifter.
module rip_uart_tx
    import rip_mmio_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned FIFO_DEPTH   = 8,
    parameter int unsigned CNT_W        = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             push,
    input  logic [7:0]       data,
    input  logic             ovf_clr,
    output logic             full_c,
    output logic             empty_c,
    output logic [CNT_W-1:0] count,
    output logic             busy_c,
    output logic             ovf,
    output logic             UART_TX
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CPB_W = $clog2(CLKS_PER_BIT);
    localparam logic [CPB_W-1:0] BIT_RELOAD = CPB_W'(CLKS_PER_BIT - 1);

    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             ovf_q;
    logic             pop_c, push_ok_c;

    uart_state_e      state_q, state_d;
    logic [CPB_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q, tx_d;

    assign empty_c   = (count_q == '0);
    assign full_c    = (count_q == CNT_W'(FIFO_DEPTH));
    assign busy_c    = (state_q != UART_IDLE);
    assign pop_c     = (state_q == UART_IDLE) && !empty_c;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign push_ok_c = push && (!full_c || pop_c);
    assign count     = count_q;
    assign ovf       = ovf_q;
    assign UART_TX   = tx_q;

    // Storage carries no reset; pointers and count define validity.
    always_ff @(posedge CLK) begin
        if (push_ok_c) mem_q[wr_ptr_q] <= data;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (push_ok_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_c)     rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push_ok_c, pop_c})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
            if (ovf_clr)                 ovf_q <= 1'b0;
            else if (push && !push_ok_c) ovf_q <= 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= UART_IDLE;
            bit_cnt_q <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
        end
    end

    // Each state holds the line for one bit time, then reloads the counter.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        case (state_q)
            UART_IDLE: begin
                tx_d = 1'b1;
                if (pop_c) begin
                    state_d   = UART_START;
                    shift_d   = mem_q[rd_ptr_q];
                    bit_cnt_d = BIT_RELOAD;
                    tx_d      = 1'b0;
                end
            end
            UART_START: begin
                if (bit_cnt_q == '0) begin
                    state_d   = UART_DATA;
                    bit_cnt_d = BIT_RELOAD;
                    bit_idx_d = '0;
                    tx_d      = shift_q[0];
                end else begin
                    bit_cnt_d = bit_cnt_q - CPB_W'(1);
                end
            end
            UART_DATA: begin
                if (bit_cnt_q == '0) begin
                    bit_cnt_d = BIT_RELOAD;
                    if (bit_idx_q == 3'd7) begin
                        state_d = UART_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        shift_d   = {1'b0, shift_q[7:1]};
                        tx_d      = shift_q[1];
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q - CPB_W'(1);
                end
            end
            UART_STOP: begin
                tx_d = 1'b1;
                if (bit_cnt_q == '0) state_d = UART_IDLE;
                else                 bit_cnt_d = bit_cnt_q - CPB_W'(1);
            end
            default: begin
                state_d = UART_IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/rip_mmio_responder.sv
// MMIO responder: address decode, 64-bit timer with compare interrupt,
// UART TX registers, and single-cycle registered responses.
module rip_mmio_responder
    import rip_mmio_pkg::*;
#(
    parameter logic [31:0] MMIO_BASE    = 32'hFFFF_0000,
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned FIFO_DEPTH   = 8
) (
    input  logic                 CLK,
    input  logic                 RST,
    rip_mmio_responder_if.slave  bus,
    output logic                 IRQ_TIMER,
    output logic                 UART_TX
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [OFF_W-1:0]  off_c;
    logic              accept_c, rd_c, wr_c;
    logic [DATA_W-1:0] rdata_c, status_c;
    logic [3:0]        count_sat_c;

    logic [63:0]       mtime_q, mtimecmp_q;
    logic [31:0]       shadow_q;
    logic              irq_q;
    logic              rsp_valid_q, rsp_err_q;
    logic [DATA_W-1:0] rsp_rdata_q;

    logic              uart_full_c, uart_empty_c, uart_busy_c, uart_ovf;
    logic [CNT_W-1:0]  uart_count;

    assign off_c = bus.REQ_ADDR[OFF_W-1:0];

    always_comb begin
        accept_c = bus.REQ_VALID
                && (req_size_e'(bus.REQ_SIZE) == SIZE_WORD)
                && (bus.REQ_ADDR[1:0] == 2'b00)
                && (bus.REQ_ADDR[ADDR_W-1:OFF_W] == MMIO_BASE[ADDR_W-1:OFF_W])
                && reg_mapped(off_c, bus.REQ_WE);
        rd_c = accept_c && !bus.REQ_WE;
        wr_c = accept_c &&  bus.REQ_WE;
    end

    rip_uart_tx #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .FIFO_DEPTH   (FIFO_DEPTH),
        .CNT_W        (CNT_W)
    ) u_uart_tx (
        .CLK     (CLK),
        .RST     (RST),
        .push    (wr_c && (off_c == OFF_UART_TXDATA)),
        .data    (bus.REQ_WDATA[7:0]),
        .ovf_clr (wr_c && (off_c == OFF_UART_STATUS) && bus.REQ_WDATA[ST_OVF]),
        .full_c  (uart_full_c),
        .empty_c (uart_empty_c),
        .count   (uart_count),
        .busy_c  (uart_busy_c),
        .ovf     (uart_ovf),
        .UART_TX (UART_TX)
    );

    always_comb begin
        count_sat_c = (32'(uart_count) > 32'd15) ? 4'hF : 4'(uart_count);
        status_c                          = '0;
        status_c[ST_BUSY]                 = uart_busy_c;
        status_c[ST_FULL]                 = uart_full_c;
        status_c[ST_EMPTY]                = uart_empty_c;
        status_c[ST_OVF]                  = uart_ovf;
        status_c[ST_CNT_LSB +: ST_CNT_W]  = count_sat_c;
    end

    always_comb begin
        rdata_c = '0;
        case (off_c)
            OFF_MTIME_LO:    rdata_c = mtime_q[31:0];
            OFF_MTIME_HI:    rdata_c = shadow_q;
            OFF_MTIMECMP_LO: rdata_c = mtimecmp_q[31:0];
            OFF_MTIMECMP_HI: rdata_c = mtimecmp_q[63:32];
            OFF_UART_STATUS: rdata_c = status_c;
            default:         rdata_c = '0;
        endcase
    end

    // Reading MTIME_LO latches the upper half so a LO/HI pair is coherent.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            mtime_q    <= '0;
            shadow_q   <= '0;
            mtimecmp_q <= '1;
            irq_q      <= 1'b0;
        end else begin
            mtime_q <= mtime_q + 64'd1;
            irq_q   <= (mtime_q >= mtimecmp_q);
            if (rd_c && (off_c == OFF_MTIME_LO))    shadow_q          <= mtime_q[63:32];
            if (wr_c && (off_c == OFF_MTIMECMP_LO)) mtimecmp_q[31:0]  <= bus.REQ_WDATA;
            if (wr_c && (off_c == OFF_MTIMECMP_HI)) mtimecmp_q[63:32] <= bus.REQ_WDATA;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            rsp_valid_q <= bus.REQ_VALID;
            rsp_err_q   <= bus.REQ_VALID && !accept_c;
            rsp_rdata_q <= rd_c ? rdata_c : '0;
        end
    end

    assign bus.RSP_VALID = rsp_valid_q;
    assign bus.RSP_ERR   = rsp_err_q;
    assign bus.RSP_RDATA = rsp_rdata_q;
    assign IRQ_TIMER     = irq_q;

endmodule

// File: tb/tb_rip_mmio_responder.sv
// Self-checking bench for rip_mmio_responder with a fast UART bit time.
module tb_rip_mmio_responder;

    localparam logic [31:0] BASE = 32'hFFFF_0000;
    localparam int          CPB  = 4;
    localparam int          DEPTH = 8;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic irq, tx;

    rip_mmio_responder_if bus ();

    rip_mmio_responder #(
        .MMIO_BASE    (BASE),
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .bus       (bus),
        .IRQ_TIMER (irq),
        .UART_TX   (tx)
    );

    always #5 CLK = ~CLK;

    // Elapsed clock edges since reset release: the value mtime should hold.
    logic [63:0] cyc;
    always @(posedge CLK or posedge RST) begin
        if (RST) cyc <= 64'd0;
        else     cyc <= cyc + 64'd1;
    end

    int n_checks = 0;
    int n_fail   = 0;

    logic        r_valid, r_err, r_irq;
    logic [31:0] r_data;
    logic [63:0] cmp_m;
    logic [31:0] shadow_m;

    // One request, response captured just after the sampling edge; ends on a negedge.
    task automatic do_req(input logic we, input logic [1:0] size,
                          input logic [31:0] addr, input logic [31:0] wdata);
        bus.REQ_VALID = 1'b1;
        bus.REQ_WE    = we;
        bus.REQ_SIZE  = size;
        bus.REQ_ADDR  = addr;
        bus.REQ_WDATA = wdata;
        @(posedge CLK);
        #1;
        r_valid = bus.RSP_VALID;
        r_err   = bus.RSP_ERR;
        r_data  = bus.RSP_RDATA;
        r_irq   = irq;
        bus.REQ_VALID = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_reset();
        #12;
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b want 0", irq); end
        n_checks++; if (tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b want 1", tx); end
        n_checks++; if (bus.RSP_VALID !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 0", bus.RSP_VALID); end
        @(negedge CLK);
        RST = 1'b0;
        for (int i = 0; i < 20 && cyc != 64'd5; i++) @(negedge CLK);
        do_req(1'b0, 2'b10, BASE + 32'h0, 32'h0);
        n_checks++; if (r_valid !== 1'b1 || r_err !== 1'b0 || r_data !== 32'd5) begin
            n_fail++; $display("FAIL reset_mtime_lo: got v=%b e=%b d=%0d want v=1 e=0 d=5", r_valid, r_err, r_data);
        end
        do_req(1'b0, 2'b10, BASE + 32'h4, 32'h0);
        n_checks++; if (r_data !== 32'd0 || r_err !== 1'b0) begin
            n_fail++; $display("FAIL reset_mtime_hi: got e=%b d=%0h want e=0 d=0", r_err, r_data);
        end
        n_checks++; if (irq !== 1'b0 || tx !== 1'b1) begin
            n_fail++; $display("FAIL reset_outputs: got irq=%b tx=%b want irq=0 tx=1", irq, tx);
        end
        cmp_m    = '1;
        shadow_m = 32'd0;
    endtask

    task automatic test_timer();
        do_req(1'b1, 2'b10, BASE + 32'h8, 32'd20);
        do_req(1'b1, 2'b10, BASE + 32'hC, 32'd0);
        cmp_m = 64'd20;
        n_checks++; if (r_err !== 1'b0) begin n_fail++; $display("FAIL timer_cmp_write: got err=%b want 0", r_err); end
        // irq seen in a cycle reflects mtime of the previous cycle against cmp
        for (int i = 0; i < 40 && cyc < 64'd26; i++) begin
            @(negedge CLK);
            n_checks++; if (irq !== ((cyc - 64'd1) >= cmp_m)) begin
                n_fail++; $display("FAIL timer_rise: at mtime=%0d got irq=%b want %b", cyc, irq, (cyc - 64'd1) >= cmp_m);
            end
        end
        do_req(1'b1, 2'b10, BASE + 32'h8, 32'hFFFF_FFFF);
        n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL timer_drop_early: got irq=%b want 1", irq); end
        @(negedge CLK);
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL timer_drop: got irq=%b want 0", irq); end
        do_req(1'b1, 2'b10, BASE + 32'hC, 32'hFFFF_FFFF);
        cmp_m = '1;
        @(negedge CLK);
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL timer_off: got irq=%b want 0", irq); end
    endtask

    task automatic test_uart_frame(input logic [7:0] data);
        logic [9:0] frame;
        frame = {1'b1, data, 1'b0};
        do_req(1'b1, 2'b10, BASE + 32'h10, {24'h0, data});
        n_checks++; if (r_err !== 1'b0) begin n_fail++; $display("FAIL uart_push_err: got %b want 0", r_err); end
        n_checks++; if (tx !== 1'b1) begin n_fail++; $display("FAIL uart_latency: got tx=%b want 1 one cycle after push", tx); end
        for (int i = 0; i < 10 * CPB; i++) begin
            @(negedge CLK);
            n_checks++; if (tx !== frame[i / CPB]) begin
                n_fail++; $display("FAIL uart_bit %0d of %h: got %b want %b", i, data, tx, frame[i / CPB]);
            end
            if (i == 20) begin
                bus.REQ_VALID = 1'b1; bus.REQ_WE = 1'b0; bus.REQ_SIZE = 2'b10; bus.REQ_ADDR = BASE + 32'h14;
            end
            if (i == 21) begin
                bus.REQ_VALID = 1'b0;
                n_checks++; if (bus.RSP_RDATA !== 32'h5) begin
                    n_fail++; $display("FAIL uart_status_busy: got %h want 5", bus.RSP_RDATA);
                end
            end
        end
        @(negedge CLK);
        do_req(1'b0, 2'b10, BASE + 32'h14, 32'h0);
        n_checks++; if (r_data !== 32'h4) begin n_fail++; $display("FAIL uart_status_idle: got %h want 4", r_data); end
    endtask

    task automatic test_errors();
        logic [31:0] addrs [7];
        logic        wes   [7];
        logic [1:0]  sizes [7];
        addrs = '{BASE + 32'h0, BASE + 32'h2, BASE + 32'h18, BASE + 32'h4, BASE - 32'h4, BASE + 32'hA, BASE + 32'h10};
        wes   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        sizes = '{2'b00, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b00};
        @(negedge CLK);
        n_checks++; if (bus.RSP_VALID !== 1'b0) begin n_fail++; $display("FAIL idle_rsp_valid: got %b want 0", bus.RSP_VALID); end
        for (int i = 0; i < 7; i++) begin
            do_req(wes[i], sizes[i], addrs[i], 32'h1234_5678);
            n_checks++; if (r_valid !== 1'b1 || r_err !== 1'b1 || r_data !== 32'h0) begin
                n_fail++; $display("FAIL err_case %0d addr=%h: got v=%b e=%b d=%h want v=1 e=1 d=0", i, addrs[i], r_valid, r_err, r_data);
            end
        end
        do_req(1'b0, 2'b10, BASE + 32'h8, 32'h0);
        n_checks++; if (r_data !== cmp_m[31:0]) begin n_fail++; $display("FAIL err_cmp_lo_kept: got %h want %h", r_data, cmp_m[31:0]); end
        do_req(1'b0, 2'b10, BASE + 32'h4, 32'h0);
        n_checks++; if (r_data !== shadow_m) begin n_fail++; $display("FAIL err_shadow_kept: got %h want %h", r_data, shadow_m); end
        do_req(1'b0, 2'b10, BASE + 32'h14, 32'h0);
        n_checks++; if (r_data !== 32'h4 || tx !== 1'b1) begin n_fail++; $display("FAIL err_no_push: got status=%h tx=%b want 4/1", r_data, tx); end
    endtask

    task automatic test_fifo_overflow();
        logic done;
        for (int k = 0; k < DEPTH + 1; k++) begin
            do_req(1'b1, 2'b10, BASE + 32'h10, 32'($urandom_range(0, 255)));
            n_checks++; if (r_err !== 1'b0) begin n_fail++; $display("FAIL fifo_push %0d: got err=%b want 0", k, r_err); end
        end
        do_req(1'b0, 2'b10, BASE + 32'h14, 32'h0);
        n_checks++; if (r_data !== 32'h83) begin n_fail++; $display("FAIL fifo_full_status: got %h want 83", r_data); end
        do_req(1'b1, 2'b10, BASE + 32'h10, 32'h5A);
        do_req(1'b0, 2'b10, BASE + 32'h14, 32'h0);
        n_checks++; if (r_data !== 32'h8B) begin n_fail++; $display("FAIL fifo_ovf_status: got %h want 8b", r_data); end
        do_req(1'b1, 2'b10, BASE + 32'h14, 32'h8);
        do_req(1'b0, 2'b10, BASE + 32'h14, 32'h0);
        n_checks++; if (r_data !== 32'h83) begin n_fail++; $display("FAIL fifo_ovf_clear: got %h want 83", r_data); end
        done = 1'b0;
        for (int i = 0; i < 1000 && !done; i++) begin
            do_req(1'b0, 2'b10, BASE + 32'h14, 32'h0);
            if (r_data == 32'h4) done = 1'b1;
        end
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL fifo_drain: got status=%h want 4 within bound", r_data); end
    endtask

    task automatic test_random();
        logic        we, ok, exp_irq;
        logic [1:0]  size;
        logic [7:0]  off;
        logic [31:0] addr, wdata, exp_data;
        for (int n = 0; n < 200; n++) begin
            case ($urandom_range(0, 7))
                0: off = 8'h00;  1: off = 8'h04;  2: off = 8'h08;  3: off = 8'h0C;
                4: off = 8'h14;  5: off = 8'h10;
                6: off = 8'(8'h18 + 4 * $urandom_range(0, 57));
                default: off = 8'($urandom_range(0, 255));
            endcase
            size = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b10;
            addr = ($urandom_range(0, 7) == 0) ? {24'($urandom), off} : {BASE[31:8], off};
            we   = 1'($urandom_range(0, 1));
            if (we && off == 8'h10) we = 1'b0;
            if (off == 8'h0C) wdata = ($urandom_range(0, 2) != 0) ? 32'h0 : $urandom;
            else              wdata = ($urandom_range(0, 1) != 0) ? 32'(cyc[31:0] + 32'($urandom_range(0, 30))) - 32'd15 : $urandom;
            case (off)
                8'h00, 8'h04:                ok = !we;
                8'h08, 8'h0C, 8'h10, 8'h14:  ok = 1'b1;
                default:                     ok = 1'b0;
            endcase
            ok = ok && (size == 2'b10) && (addr[1:0] == 2'b00) && (addr[31:8] == BASE[31:8]);
            exp_irq  = (cyc >= cmp_m);
            exp_data = 32'h0;
            if (ok && !we) begin
                case (off)
                    8'h00: begin exp_data = cyc[31:0]; shadow_m = cyc[63:32]; end
                    8'h04: exp_data = shadow_m;
                    8'h08: exp_data = cmp_m[31:0];
                    8'h0C: exp_data = cmp_m[63:32];
                    8'h14: exp_data = 32'h4;
                    default: exp_data = 32'h0;
                endcase
            end
            do_req(we, size, addr, wdata);
            if (ok && we && off == 8'h08) cmp_m[31:0]  = wdata;
            if (ok && we && off == 8'h0C) cmp_m[63:32] = wdata;
            n_checks++; if (r_valid !== 1'b1 || r_err !== !ok) begin
                n_fail++; $display("FAIL rand_err %0d addr=%h we=%b size=%b: got v=%b e=%b want v=1 e=%b", n, addr, we, size, r_valid, r_err, !ok);
            end
            n_checks++; if (r_data !== exp_data) begin
                n_fail++; $display("FAIL rand_data %0d addr=%h: got %h want %h", n, addr, r_data, exp_data);
            end
            n_checks++; if (r_irq !== exp_irq) begin
                n_fail++; $display("FAIL rand_irq %0d: got %b want %b", n, r_irq, exp_irq);
            end
            n_checks++; if (tx !== 1'b1) begin n_fail++; $display("FAIL rand_tx %0d: got %b want 1", n, tx); end
        end
    endtask

    task automatic test_reset_midframe();
        do_req(1'b1, 2'b10, BASE + 32'h8, 32'h0);
        do_req(1'b1, 2'b10, BASE + 32'hC, 32'h0);
        do_req(1'b1, 2'b10, BASE + 32'h10, 32'h0);
        repeat (8) @(negedge CLK);
        n_checks++; if (tx !== 1'b0 || irq !== 1'b1) begin
            n_fail++; $display("FAIL midframe_pre: got tx=%b irq=%b want 0/1", tx, irq);
        end
        bus.REQ_VALID = 1'b1; bus.REQ_WE = 1'b0; bus.REQ_SIZE = 2'b10; bus.REQ_ADDR = BASE + 32'h0;
        @(posedge CLK);
        #1;
        bus.REQ_VALID = 1'b0;
        n_checks++; if (bus.RSP_VALID !== 1'b1) begin n_fail++; $display("FAIL midframe_rsp_pre: got %b want 1", bus.RSP_VALID); end
        #1;
        RST = 1'b1;
        #1;
        n_checks++; if (tx !== 1'b1 || bus.RSP_VALID !== 1'b0 || bus.RSP_ERR !== 1'b0 || bus.RSP_RDATA !== 32'h0 || irq !== 1'b0) begin
            n_fail++; $display("FAIL midframe_async: got tx=%b v=%b e=%b d=%h irq=%b want 1/0/0/0/0",
                               tx, bus.RSP_VALID, bus.RSP_ERR, bus.RSP_RDATA, irq);
        end
        @(negedge CLK);
        RST = 1'b0;
        cmp_m    = '1;
        shadow_m = 32'h0;
        do_req(1'b0, 2'b10, BASE + 32'h14, 32'h0);
        n_checks++; if (r_data !== 32'h4) begin n_fail++; $display("FAIL midframe_fifo: got status=%h want 4", r_data); end
        do_req(1'b0, 2'b10, BASE + 32'hC, 32'h0);
        n_checks++; if (r_data !== cmp_m[63:32]) begin n_fail++; $display("FAIL midframe_cmp: got %h want %h", r_data, cmp_m[63:32]); end
        for (int i = 0; i < 3 * CPB; i++) begin
            @(negedge CLK);
            n_checks++; if (tx !== 1'b1) begin n_fail++; $display("FAIL midframe_line %0d: got %b want 1", i, tx); end
        end
    endtask

    initial begin
        bus.REQ_VALID = 1'b0;
        bus.REQ_WE    = 1'b0;
        bus.REQ_SIZE  = 2'b00;
        bus.REQ_ADDR  = 32'h0;
        bus.REQ_WDATA = 32'h0;
        cmp_m    = '1;
        shadow_m = 32'h0;
        test_reset();
        test_timer();
        test_uart_frame(8'hA5);
        test_uart_frame(8'($urandom_range(0, 255)));
        test_errors();
        test_fifo_overflow();
        test_random();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time bound");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/rip_mmio_responder.md
# rip_mmio_responder

Memory-mapped I/O responder on the core's data port. It serves word loads and stores that the memory unit routes to the MMIO window, with a fixed one-cycle response latency that matches the MA→WB handoff. It provides:

- a free-running 64-bit cycle timer with compare interrupt;
- a FIFO-buffered 8N1 UART transmitter.

## Interface

Parameters:
- MMIO_BASE, 32'hFFFF_0000, base of the 256-byte window; the low 8 address bits select the register
- CLKS_PER_BIT, 868, CLK cycles per UART bit; must be ≥ 2
- FIFO_DEPTH, 8, UART TX FIFO entries; power of two, ≥ 2

Ports:
- CLK  in  1  clock; one clock domain for the whole block
- RST  in  1  reset, asynchronous, active-high
- REQ_VALID  in  1  access request this cycle
- REQ_WE  in  1  1 = store, 0 = load
- REQ_SIZE  in  2  00 byte, 01 half, 10 word, 11 reserved
- REQ_ADDR  in  32  byte address
- REQ_WDATA  in  32  store data
- RSP_VALID  out  1  response for the request of the previous cycle
- RSP_RDATA  out  32  load data; 0 for stores and errors
- RSP_ERR  out  1  request was rejected
- IRQ_TIMER  out  1  timer interrupt, level
- UART_TX  out  1  serial line; idles high

## Operation

A request is accepted when REQ_VALID=1 and it is a word access (REQ_SIZE=10), aligned (REQ_ADDR[1:0]=0), inside the window (REQ_ADDR[31:8]=MMIO_BASE[31:8]), and at a mapped offset. Any other request is an error: it has no side effects, RSP_ERR=1 and RSP_RDATA=0.

Register map (offset, access, behaviour):
- 0x00 MTIME_LO, R: returns mtime[31:0]; the same read copies mtime[63:32] into a shadow register.
- 0x04 MTIME_HI, R: returns the shadow register (holds 0 after reset until MTIME_LO is read).
- 0x08 / 0x0C MTIMECMP_LO / HI, RW: plain register halves.
- 0x10 UART_TXDATA, W: pushes WDATA[7:0] into the FIFO. If the FIFO is full, the byte is dropped and the sticky `ovf` bit is set. A read returns 0 and is not an error.
- 0x14 UART_STATUS, R/W1C:
  - bit0 busy (shifter not in IDLE)
  - bit1 full
  - bit2 empty
  - bit3 ovf
  - bits[7:4] FIFO count, saturating at 15
  - Writing 1 to bit3 clears ovf; all other bits ignore writes.
- Stores to read-only offsets 0x00 and 0x04 are errors.

Timer:
- mtime increments every cycle and wraps modulo 2^64.
- IRQ_TIMER = registered (mtime ≥ mtimecmp), as an unsigned 64-bit compare.

UART shifter FSM:
- IDLE → START when the FIFO is non-empty; the head byte is popped in the same cycle.
- START: line 0 for one bit time → DATA.
- DATA: 8 bits, LSB first, one bit time each → STOP.
- STOP: line 1 for one bit time → IDLE.
- Bit time is CLKS_PER_BIT cycles, counted by a down-counter reloaded with CLKS_PER_BIT-1.

## Timing

- Response latency is 1 cycle: RSP_VALID/RSP_RDATA/RSP_ERR are registered and appear the cycle after REQ_VALID. Back-to-back requests give back-to-back responses. There is no backpressure.
- Register writes take effect at the sampling edge. A read of MTIME_LO returns mtime as sampled at that edge.
- FIFO push and pop in the same cycle: count is unchanged, and a full FIFO accepts the push with no overflow. A push into an empty FIFO while the shifter is IDLE gives a START line value 2 cycles after the request.
- Idle-to-idle time per byte: 10·CLKS_PER_BIT cycles after START begins.
- A write to MTIMECMP raises or lowers IRQ_TIMER 1 cycle after the write edge.
- Reset values (asynchronous; all state cleared, including mid-frame and FIFO contents):
  - mtime=0, shadow=0, mtimecmp=all-ones
  - IRQ_TIMER=0, UART_TX=1, FSM=IDLE
  - FIFO empty, ovf=0
  - RSP_VALID=0, RSP_ERR=0, RSP_RDATA=0

## Structure

- Shared package rip_mmio_pkg holds:
  - register offset localparams
  - REQ_SIZE encoding enum
  - UART FSM state enum
  - UART_STATUS bit positions
- Sub-module rip_uart_tx contains the FIFO and shifter FSM. Its interface:
  - push/data/full inputs-outputs, empty, count, busy
  - the UART_TX pin
- The top level keeps the decode, timer, compare and response registers.

## Test plan

- Reset, then read 0x00 at cycle 5 → RSP_RDATA=5 (one cycle later); read 0x04 → 0; IRQ_TIMER=0; UART_TX=1.
- Write 0x08=20, 0x0C=0 → IRQ_TIMER rises the cycle after mtime reaches 20. Then write 0x08=0xFFFFFFFF, 0x0C=0xFFFFFFFF → IRQ_TIMER drops 1 cycle after the write.
- With CLKS_PER_BIT=4, write 0x10=0xA5 → UART_TX sequence 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles; busy=1 throughout; then empty=1.
- Push 9 bytes back-to-back with FIFO_DEPTH=8:
  - the first byte is popped immediately, so no drop occurs;
  - a 10th push sets ovf (status bit3=1);
  - writing 0x14=0x8 clears ovf.
- Error cases, each → RSP_ERR=1 with no state change:
  - byte read of 0x00
  - word read at offset 0x02
  - read at 0x18
  - store to 0x04
  - access at MMIO_BASE−4
- Assert RST mid-frame → UART_TX=1, FIFO empty, RSP_VALID=0 immediately, with no clock edge required.
